// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, load-wait FSM and MEM/WB bus formation.
// Optional MEM->ID bypass port mem_fwd_bus is built only when MEM_FWD_EN is defined.
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic [75:0] ex_to_mem_bus,
   input  logic [31:0] data_sram_rdata,
   input  logic        data_sram_rvalid,
   output logic [69:0] mem_to_wb_bus,
   output logic        stallreq_mem
`ifdef MEM_FWD_EN
   ,
   output logic [37:0] mem_fwd_bus
`endif
);

   localparam logic STOP = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic [75:0] r_ex;
   logic [31:0] r_buf;

   logic        w_load;
   logic        w_hold;
   logic        w_done;
   logic        w_rf_we;
   logic [31:0] w_rf_wdata;
   logic        w_unused_stall;

   // Load = data RAM enabled, no byte writes, result taken from memory.
   assign w_load = r_ex[43] & ~(|r_ex[42:39]) & r_ex[38];
   // The instruction stays in MEM only when both EX/MEM and MEM/WB hold.
   assign w_hold = (stall[3] == STOP) & (stall[4] == STOP);
   assign w_done = (r_state == S_DONE);
   assign w_unused_stall = ^{stall[5], stall[2:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex    <= '0;
         r_buf   <= '0;
         r_state <= S_IDLE;
      end else begin
         if (stall[3] != STOP) begin
            r_ex <= ex_to_mem_bus;
         end else if (stall[4] != STOP) begin
            r_ex <= '0;
         end

         // DONE is only entered while the load is still held in MEM; if it
         // leaves at the capture edge the next instruction starts from IDLE.
         case (r_state)
            S_IDLE, S_WAIT: begin
               if (w_load) begin
                  if (data_sram_rvalid) begin
                     r_buf   <= data_sram_rdata;
                     r_state <= w_hold ? S_DONE : S_IDLE;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_DONE: begin
               if (!w_hold) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign stallreq_mem = w_load & ~w_done & ~data_sram_rvalid;
   assign w_rf_wdata   = w_load ? (w_done ? r_buf : data_sram_rdata) : r_ex[31:0];
   assign w_rf_we      = r_ex[37] & ~stallreq_mem;

   assign mem_to_wb_bus = {r_ex[75:44], w_rf_we, r_ex[36:32], w_rf_wdata};

`ifdef MEM_FWD_EN
   assign mem_fwd_bus = {w_rf_we, r_ex[36:32], w_rf_wdata};
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, multi-cycle load sequences,
// then randomized traffic against a behavioural model.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic [75:0] ex_bus;
   logic [31:0] rdata;
   logic        rvalid;
   logic [69:0] wb_bus;
   logic        stallreq;
`ifdef MEM_FWD_EN
   logic [37:0] fwd_bus;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [5:0] HOLD   = 6'b011111;
   localparam logic [5:0] BUBBLE = 6'b001111;
   localparam logic [5:0] RUN    = 6'b000000;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .ex_to_mem_bus    (ex_bus),
      .data_sram_rdata  (rdata),
      .data_sram_rvalid (rvalid),
      .mem_to_wb_bus    (wb_bus),
      .stallreq_mem     (stallreq)
`ifdef MEM_FWD_EN
      ,
      .mem_fwd_bus      (fwd_bus)
`endif
   );

   function automatic logic [75:0] mk(input logic [31:0] pc, input logic en, input logic [3:0] wen,
                                      input logic sel, input logic we, input logic [4:0] wa,
                                      input logic [31:0] res);
      return {pc, en, wen, sel, we, wa, res};
   endfunction

   function automatic logic [69:0] wb(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                      input logic [31:0] wd);
      return {pc, we, wa, wd};
   endfunction

   task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input logic [69:0] exp_bus, input logic exp_sr);
      check({name, ".bus"}, wb_bus, exp_bus);
      check({name, ".stallreq"}, {69'b0, stallreq}, {69'b0, exp_sr});
`ifdef MEM_FWD_EN
      check({name, ".fwd"}, {32'b0, fwd_bus}, {32'b0, exp_bus[37:0]});
`endif
   endtask

   // Only pc/rf_we/rf_waddr are defined while a load is still waiting.
   task automatic check_wait(input string name, input logic [69:0] exp_bus);
      check({name, ".hdr"}, {32'b0, wb_bus[69:32]}, {32'b0, exp_bus[69:32]});
      check({name, ".stallreq"}, {69'b0, stallreq}, {69'b0, 1'b1});
`ifdef MEM_FWD_EN
      check({name, ".fwd_we"}, {69'b0, fwd_bus[37]}, 70'b0);
`endif
   endtask

   task automatic drive(input logic r, input logic [5:0] st, input logic [75:0] b,
                        input logic rv, input logic [31:0] rd);
      @(negedge clk);
      rst    = r;
      stall  = st;
      ex_bus = b;
      rvalid = rv;
      rdata  = rd;
      #1;
   endtask

   typedef struct {
      string       name;
      logic [5:0]  st;
      logic [75:0] bus;
      logic        rv;
      logic [31:0] rd;
      logic [69:0] exp_bus;
      logic        exp_sr;
   } vec_t;

   vec_t tbl[6];

   logic [75:0] m_ins;
   logic        m_have;
   logic [31:0] m_data;

   initial begin
      logic [75:0] l2, n2, l3, n3, l4, b;
      logic [69:0] e_bus;
      logic        e_sr, is_ld, rv, r;
      logic [31:0] rd, e_wd;
      logic [5:0]  us, st;
      int          k;

      rst = 1'b1; stall = RUN; ex_bus = '0; rvalid = 1'b0; rdata = '0;

      drive(1'b1, RUN, mk(32'hFFFF_0000, 1, 0, 1, 1, 5'd7, 32'h1), 1'b1, 32'hFFFF_FFFF);
      drive(1'b1, HOLD, '0, 1'b1, 32'h1234_5678);
      check_out("reset", '0, 1'b0);

      tbl[0] = '{"alu_in",  RUN,    mk(32'hBFC0_0000, 0, 0, 0, 1, 5'd5, 32'h1234), 0, 32'h0,
                 '0, 0};
      tbl[1] = '{"alu_out", RUN,    mk(32'hBFC0_0004, 1, 0, 1, 1, 5'd8, 32'h100), 0, 32'h0,
                 wb(32'hBFC0_0000, 1, 5'd5, 32'h1234), 0};
      tbl[2] = '{"ld_zero", RUN,    mk(32'hBFC0_0008, 0, 0, 0, 0, 5'd0, 32'h0), 1, 32'hDEAD_BEEF,
                 wb(32'hBFC0_0004, 1, 5'd8, 32'hDEAD_BEEF), 0};
      tbl[3] = '{"nop_out", BUBBLE, mk(32'hBFC0_000C, 0, 0, 0, 1, 5'd3, 32'h77), 0, 32'h0,
                 wb(32'hBFC0_0008, 0, 5'd0, 32'h0), 0};
      tbl[4] = '{"bubble",  RUN,    mk(32'hBFC0_0010, 1, 4'hF, 0, 0, 5'd0, 32'h200), 0, 32'h0,
                 '0, 0};
      tbl[5] = '{"store",   RUN,    '0, 1, 32'h999,
                 wb(32'hBFC0_0010, 0, 5'd0, 32'h200), 0};
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, tbl[i].st, tbl[i].bus, tbl[i].rv, tbl[i].rd);
         check_out(tbl[i].name, tbl[i].exp_bus, tbl[i].exp_sr);
      end

      // Two-wait load.
      l2 = mk(32'hBFC0_0020, 1, 0, 1, 1, 5'd9, 32'h104);
      n2 = mk(32'hBFC0_0024, 0, 0, 0, 1, 5'd2, 32'h55);
      drive(1'b0, RUN, l2, 1'b0, 32'h0);
      check_out("ld2_pre", '0, 1'b0);
      drive(1'b0, HOLD, n2, 1'b0, 32'h0);
      check_wait("ld2_w1", wb(32'hBFC0_0020, 0, 5'd9, 32'h0));
      drive(1'b0, HOLD, n2, 1'b0, 32'h1);
      check_wait("ld2_w2", wb(32'hBFC0_0020, 0, 5'd9, 32'h0));
      drive(1'b0, RUN, n2, 1'b1, 32'hCAFE_F00D);
      check_out("ld2_done", wb(32'hBFC0_0020, 1, 5'd9, 32'hCAFE_F00D), 1'b0);
      drive(1'b0, RUN, '0, 1'b0, 32'h0);
      check_out("ld2_next", wb(32'hBFC0_0024, 1, 5'd2, 32'h55), 1'b0);

      // Load completes while MEM/WB is held; buffered value must persist.
      l3 = mk(32'hBFC0_0030, 1, 0, 1, 1, 5'd10, 32'h108);
      n3 = mk(32'hBFC0_0034, 0, 0, 0, 1, 5'd4, 32'h66);
      drive(1'b0, RUN, l3, 1'b0, 32'h0);
      check_out("ld3_pre", '0, 1'b0);
      drive(1'b0, HOLD, n3, 1'b1, 32'h1111_2222);
      check_out("ld3_cap", wb(32'hBFC0_0030, 1, 5'd10, 32'h1111_2222), 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, HOLD, n3, i[0], 32'h0);
         check_out("ld3_hold", wb(32'hBFC0_0030, 1, 5'd10, 32'h1111_2222), 1'b0);
      end
      drive(1'b0, RUN, n3, 1'b0, 32'h0);
      check_out("ld3_rel", wb(32'hBFC0_0030, 1, 5'd10, 32'h1111_2222), 1'b0);
      drive(1'b0, RUN, '0, 1'b0, 32'h0);
      check_out("ld3_next", wb(32'hBFC0_0034, 1, 5'd4, 32'h66), 1'b0);

      // Reset while waiting; a late rvalid must be ignored.
      l4 = mk(32'hBFC0_0040, 1, 0, 1, 1, 5'd11, 32'h10C);
      drive(1'b0, RUN, l4, 1'b0, 32'h0);
      check_out("ld4_pre", '0, 1'b0);
      drive(1'b0, HOLD, '0, 1'b0, 32'h0);
      check_wait("ld4_wait", wb(32'hBFC0_0040, 0, 5'd11, 32'h0));
      drive(1'b1, HOLD, '0, 1'b0, 32'h0);
      drive(1'b0, HOLD, '0, 1'b1, 32'h7777_7777);
      check_out("rst_wait", '0, 1'b0);
      drive(1'b0, RUN, '0, 1'b1, 32'h8888_8888);
      check_out("rst_stray", '0, 1'b0);

      // Randomized traffic; the bench acts as the stall controller.
      drive(1'b1, RUN, '0, 1'b0, 32'h0);
      m_ins = '0; m_have = 1'b0; m_data = '0;
      for (int c = 0; c < 800; c++) begin
         r = ($urandom_range(0, 59) == 0);
         b = {$urandom, $urandom, $urandom};
         k = $urandom_range(0, 9);
         if (k < 4) begin
            b[43] = 1'b1; b[42:39] = 4'h0; b[38] = 1'b1;
         end else if (k < 6) begin
            b[43] = 1'b1; b[42:39] = 4'($urandom_range(1, 15)); b[38] = 1'b0;
         end else begin
            b[43] = 1'b0;
         end
         rv = ($urandom_range(0, 2) == 0);
         rd = $urandom;
         k  = $urandom_range(0, 9);
         us = (k < 6) ? RUN : ((k < 8) ? BUBBLE : HOLD);

         is_ld = m_ins[43] && (m_ins[42:39] == 4'h0) && m_ins[38];
         e_sr  = is_ld && !m_have && !rv;
         e_wd  = !is_ld ? m_ins[31:0] : (m_have ? m_data : rd);
         e_bus = {m_ins[75:44], m_ins[37] && !e_sr, m_ins[36:32], e_wd};
         st    = e_sr ? HOLD : us;

         drive(r, st, b, rv, rd);
         if (e_sr) check_wait("rand", e_bus);
         else      check_out("rand", e_bus, 1'b0);

         if (r) begin
            m_ins = '0; m_have = 1'b0; m_data = '0;
         end else begin
            if (is_ld && !m_have && rv && st[3] && st[4]) begin
               m_have = 1'b1;
               m_data = rd;
            end
            if (!st[3]) begin
               m_ins = b; m_have = 1'b0;
            end else if (!st[4]) begin
               m_ins = '0; m_have = 1'b0;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk  input  1  pipeline clock, all state on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port stall  input  `StallBus (6)  global stall vector; bit 3 holds the EX/MEM register, bit 4 holds the MEM/WB register.
REQ-004 SHALL have port ex_to_mem_bus  input  `EX_TO_MEM_WD (76)  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
REQ-005 SHALL have port data_sram_rdata  input  32  load data from data SRAM.
REQ-006 SHALL have port data_sram_rvalid  input  1  load data valid this cycle.
REQ-007 SHALL have port mem_to_wb_bus  output  `MEM_TO_WB_WD (70)  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
REQ-008 SHALL have port stallreq_mem  output  1  MEM stage requests pipeline stall while a load awaits data.
REQ-009 SHALL have port mem_fwd_bus  output  38  {rf_we, rf_waddr, rf_wdata} to ID bypass; present only under MEM_FWD_EN.

Function
REQ-010 SHALL latch ex_to_mem_bus into an internal register when stall[3]==NoStop.
REQ-011 SHALL load all-zero (bubble) when stall[3]==Stop and stall[4]==NoStop.
REQ-012 SHALL hold the register when stall[3]==Stop and stall[4]==Stop.
REQ-013 SHALL treat a registered instruction with data_ram_en=1, data_ram_wen=0, sel_rf_res=1 as a load; stores (wen!=0) complete with no wait.
REQ-014 SHALL implement FSM states IDLE, WAIT, DONE; reset state IDLE.
REQ-015 IDLE: on a load present in the register, SHALL go DONE if data_sram_rvalid=1 this cycle (capturing rdata), else WAIT.
REQ-016 WAIT: SHALL assert stallreq_mem=1; on data_sram_rvalid=1 SHALL capture data_sram_rdata into a 32-bit load buffer and go DONE.
REQ-017 DONE: stallreq_mem=0; on stall[3]==NoStop SHALL go IDLE, or directly WAIT/DONE per REQ-015 if the newly latched instruction is a load.
REQ-018 SHALL ignore data_sram_rvalid in IDLE with no load present and in DONE (no buffer overwrite).
REQ-019 stallreq_mem SHALL be combinational: 1 in IDLE when a load is present and rvalid=0, 1 in WAIT while rvalid=0, else 0.
REQ-020 rf_wdata SHALL be: same-cycle data_sram_rdata when a load completes in the cycle it is presented, load buffer in DONE, ex_result for non-loads.
REQ-021 mem_to_wb_bus rf_we SHALL be forced 0 while stallreq_mem=1 so WB never commits stale load data.
REQ-022 Bubble (all-zero register) SHALL produce mem_to_wb_bus all-zero.
REQ-023 Simultaneous rvalid and stall[3]==NoStop in WAIT SHALL be impossible by construction (stallreq_mem holds stall[3]); if it occurs, capture SHALL take precedence and FSM SHALL go DONE.

Reset
REQ-024 On rst=1 at a clock edge, SHALL clear the pipeline register, load buffer, and FSM to IDLE regardless of stall.
REQ-025 During and after reset, mem_to_wb_bus SHALL be 70'b0 and stallreq_mem SHALL be 0.
REQ-026 A load aborted by reset mid-WAIT SHALL be dropped; a later stray rvalid SHALL be ignored per REQ-018.

Configuration
REQ-027 Macro MEM_FWD_EN defined: mem_fwd_bus SHALL exist, equal {rf_we, rf_waddr, rf_wdata} of mem_to_wb_bus with rf_we=0 while stallreq_mem=1.
REQ-028 Macro MEM_FWD_EN undefined: mem_fwd_bus port SHALL be absent and no other behaviour SHALL change.

Verification
REQ-029 ALU result: bus pc=0xBFC00000, rf_we=1, waddr=5, ex_result=0x1234, no stall -> next cycle mem_to_wb_bus={0xBFC00000,1,5,0x1234}, stallreq_mem=0.
REQ-030 Zero-wait load: load waddr=8, rvalid=1 rdata=0xDEADBEEF in first MEM cycle -> rf_wdata=0xDEADBEEF, rf_we=1, stallreq_mem never 1.
REQ-031 Two-wait load: rvalid delayed 2 cycles -> stallreq_mem=1 for 2 cycles, rf_we=0 then; on rvalid rdata=0xCAFEF00D -> DONE, rf_wdata=0xCAFEF00D.
REQ-032 Downstream hold: load completes while stall[4]=Stop for 3 cycles, rdata changes to 0x0 -> rf_wdata remains captured value until release.
REQ-033 Bubble and reset: stall[3]=Stop, stall[4]=NoStop -> bus all-zero; rst=1 in WAIT -> IDLE, outputs zero, later rvalid ignored.
REQ-034 With MEM_FWD_EN: mem_fwd_bus tracks REQ-029/REQ-031 values, rf_we=0 during wait.
